// File: rtl/fmad_pkg.sv
// ============================================================================
// fmad_pkg : shared types and constants for the iterative integer MAD unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fmad_pkg;

  // Extra sum bits beyond 2*WIDTH so the exact result of the multiply-add
  // can never wrap before the range check.
  localparam int SUM_EXTRA = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ADD  = 2'd2,
    S_DONE = 2'd3
  } fmad_state_t;

  typedef struct packed {
    logic sub;
    logic negate;
    logic signedMode;
    logic accumulate;
    logic prodSign;
  } fmad_op_t;

endpackage

`default_nettype wire

// File: rtl/fmad_step.sv
// ============================================================================
// fmad_step : combinational STEP-bit partial-product generate-and-add.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module fmad_step #(
  parameter int WIDTH = 8,
  parameter int STEP  = 2,
  parameter int SHW   = $clog2(2*WIDTH)
) (
  input  logic [WIDTH-1:0]   mcand_i,
  input  logic [STEP-1:0]    digit_i,
  input  logic [SHW-1:0]     shift_i,
  input  logic [2*WIDTH-1:0] pp_i,
  output logic [2*WIDTH-1:0] pp_o
);

  logic [2*WIDTH-1:0] mcand_ext;
  logic [2*WIDTH-1:0] acc;

  assign mcand_ext = {{WIDTH{1'b0}}, mcand_i};

  // One shifted copy of the multiplicand per set multiplier bit.
  always_comb begin
    acc = pp_i;
    for (int j = 0; j < STEP; j++) begin
      if (digit_i[j]) begin
        acc = acc + (mcand_ext << (32'(shift_i) + j));
      end
    end
  end

  assign pp_o = acc;

endmodule

`default_nettype wire

// File: rtl/fmad_iter.sv
// ============================================================================
// fmad_iter : iterative fused multiply-add, +/-(M1*M2) +/- A in 2*WIDTH bits,
//             STEP multiplier bits per cycle. Optional macro FMAD_SAT_EN
//             clamps out-of-range results instead of wrapping.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module fmad_iter
  import fmad_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     fmadMulIn1,
  input  logic [WIDTH-1:0]     fmadMulIn2,
  input  logic [2*WIDTH-1:0]   fmadAddIn,
  input  logic                 sub,
  input  logic                 negate,
  input  logic                 signedMode,
  input  logic                 accumulate,
  output logic                 busy,
  output logic                 fmadDone,
  output logic [2*WIDTH-1:0]   fmadOut,
  output logic                 overflow
);

  localparam int N     = WIDTH / STEP;
  localparam int CNT_W = $clog2(N + 1);
  localparam int SHW   = $clog2(2 * WIDTH);
  localparam int OW    = 2 * WIDTH;
  localparam int SW    = OW + SUM_EXTRA;

  generate
    if ((WIDTH < 2) || (STEP < 1) || (WIDTH % STEP != 0)) begin : g_bad_cfg
      $error("fmad_iter: WIDTH must be >= 2 and a multiple of STEP");
    end
  endgenerate

  fmad_state_t state_q, state_d;

  fmad_op_t          op_q;
  logic [WIDTH-1:0]  mcand_q;
  logic [WIDTH-1:0]  mplier_q;
  logic [SHW-1:0]    shift_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [OW-1:0]     pp_q;
  logic [OW-1:0]     addend_q;
  logic [OW-1:0]     out_q;
  logic              ovf_q;
  logic              done_q;

  logic              launch;
  logic              sign1, sign2;
  logic [WIDTH-1:0]  abs1, abs2;
  fmad_op_t          op_d;
  logic [OW-1:0]     pp_next;

  logic [SW-1:0]     prod_ext, prod_sgn, add_ext, add_sgn, sum;
  logic              ovf_d;
  logic [OW-1:0]     res_d;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_MUL;
      S_MUL:   if (cnt_q == CNT_W'(1)) state_d = S_ADD;
      S_ADD:   state_d = S_DONE;
      S_DONE:  state_d = start ? S_MUL : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign launch = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // ---------------------------------------------------------- operand latch
  // Signed operands are multiplied as magnitudes; -2^(W-1) maps onto itself,
  // which reads back correctly as an unsigned magnitude.
  always_comb begin
    sign1           = signedMode & fmadMulIn1[WIDTH-1];
    sign2           = signedMode & fmadMulIn2[WIDTH-1];
    abs1            = sign1 ? (~fmadMulIn1 + 1'b1) : fmadMulIn1;
    abs2            = sign2 ? (~fmadMulIn2 + 1'b1) : fmadMulIn2;
    op_d.sub        = sub;
    op_d.negate     = negate;
    op_d.signedMode = signedMode;
    op_d.accumulate = accumulate;
    op_d.prodSign   = sign1 ^ sign2 ^ negate;
  end

  fmad_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .SHW   (SHW)
  ) u_step (
    .mcand_i (mcand_q),
    .digit_i (mplier_q[STEP-1:0]),
    .shift_i (shift_q),
    .pp_i    (pp_q),
    .pp_o    (pp_next)
  );

  // ------------------------------------------------------ exact sum + range
  always_comb begin
    prod_ext = {{SUM_EXTRA{1'b0}}, pp_q};
    prod_sgn = op_q.prodSign ? (~prod_ext + 1'b1) : prod_ext;
    add_ext  = op_q.signedMode ? {{SUM_EXTRA{addend_q[OW-1]}}, addend_q}
                               : {{SUM_EXTRA{1'b0}}, addend_q};
    add_sgn  = op_q.sub ? (~add_ext + 1'b1) : add_ext;
    sum      = prod_sgn + add_sgn;

    if (op_q.signedMode)
      ovf_d = (sum[SW-1:OW-1] != '0) && (sum[SW-1:OW-1] != '1);
    else
      ovf_d = (sum[SW-1:OW] != '0);

`ifdef FMAD_SAT_EN
    if (!ovf_d)
      res_d = sum[OW-1:0];
    else if (op_q.signedMode)
      res_d = sum[SW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    else
      res_d = sum[SW-1] ? {OW{1'b0}} : {OW{1'b1}};
`else
    res_d = sum[OW-1:0];
`endif
  end

  // --------------------------------------------------------------- datapath
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      shift_q  <= '0;
      cnt_q    <= '0;
      pp_q     <= '0;
      addend_q <= '0;
      out_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (launch) begin
        op_q     <= op_d;
        mcand_q  <= abs1;
        mplier_q <= abs2;
        shift_q  <= '0;
        cnt_q    <= CNT_W'(N);
        pp_q     <= '0;
        // A back-to-back launch from DONE sees the result just registered.
        addend_q <= accumulate ? out_q : fmadAddIn;
      end else if (state_q == S_MUL) begin
        pp_q     <= pp_next;
        mplier_q <= mplier_q >> STEP;
        shift_q  <= shift_q + SHW'(STEP);
        cnt_q    <= cnt_q - CNT_W'(1);
      end else if (state_q == S_ADD) begin
        out_q  <= res_d;
        ovf_q  <= ovf_d;
        done_q <= 1'b1;
      end
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign fmadDone = done_q;
  assign fmadOut  = out_q;
  assign overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_fmad_iter.sv
// ============================================================================
// tb_fmad_iter : directed self-checking bench for fmad_iter (WIDTH=8, STEP=2).
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_fmad_iter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  fmadMulIn1 = '0;
  logic [7:0]  fmadMulIn2 = '0;
  logic [15:0] fmadAddIn = '0;
  logic        sub = 1'b0;
  logic        negate = 1'b0;
  logic        signedMode = 1'b0;
  logic        accumulate = 1'b0;
  logic        busy;
  logic        fmadDone;
  logic [15:0] fmadOut;
  logic        overflow;

  int errors = 0;
  int checks = 0;
  int lat;
  int seen_done;

  always #5 clock = ~clock;

  fmad_iter #(.WIDTH(8), .STEP(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .fmadMulIn1 (fmadMulIn1),
    .fmadMulIn2 (fmadMulIn2),
    .fmadAddIn  (fmadAddIn),
    .sub        (sub),
    .negate     (negate),
    .signedMode (signedMode),
    .accumulate (accumulate),
    .busy       (busy),
    .fmadDone   (fmadDone),
    .fmadOut    (fmadOut),
    .overflow   (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Launches one operation and returns the number of edges from the start
  // edge to the edge that raised fmadDone (-1 on timeout). Returns at the
  // negedge inside the DONE cycle. pulse_at>0 re-asserts start (with a
  // different multiplicand) for one cycle after that many edges.
  task automatic do_op(input logic [7:0] m1, input logic [7:0] m2, input logic [15:0] a,
                       input logic s, input logic n, input logic sg, input logic acc,
                       input int pulse_at, output int latency);
    @(negedge clock);
    fmadMulIn1 = m1; fmadMulIn2 = m2; fmadAddIn = a;
    sub = s; negate = n; signedMode = sg; accumulate = acc;
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    latency = -1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      fmadMulIn1 = m1;
      if (fmadDone) begin
        latency = e;
        break;
      end
      if (e == pulse_at) begin
        start = 1'b1;
        fmadMulIn1 = 8'd7;
      end
    end
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(fmadDone), 32'd0);
    chk("rst_out", 32'(fmadOut), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;

    // 1. Unsigned 200*100 + 1000
    do_op(8'd200, 8'd100, 16'd1000, 1'b0, 1'b0, 1'b0, 1'b0, -1, lat);
    chk("t1_out", 32'(fmadOut), 32'd21000);
    chk("t1_ovf", 32'(overflow), 32'd0);
    chk("t1_lat", 32'(lat), 32'd5);
    @(negedge clock);
    chk("t1_done_one_cycle", 32'(fmadDone), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);

    // 2. Signed cases
    do_op(8'h80, 8'h80, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, -1, lat);
    chk("t2a_out", 32'(fmadOut), 32'd16384);
    chk("t2a_ovf", 32'(overflow), 32'd0);
    do_op(8'hFD, 8'd5, 16'd7, 1'b1, 1'b0, 1'b1, 1'b0, -1, lat);
    chk("t2b_out", 32'(fmadOut), 32'hFFEA);
    chk("t2b_ovf", 32'(overflow), 32'd0);

    // 3. Unsigned overflow 255*255 + 65535
    do_op(8'd255, 8'd255, 16'd65535, 1'b0, 1'b0, 1'b0, 1'b0, -1, lat);
`ifdef FMAD_SAT_EN
    chk("t3_out", 32'(fmadOut), 32'd65535);
`else
    chk("t3_out", 32'(fmadOut), 32'd65024);
`endif
    chk("t3_ovf", 32'(overflow), 32'd1);

    // 4. Unsigned negate
    do_op(8'd5, 8'd5, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, -1, lat);
`ifdef FMAD_SAT_EN
    chk("t4a_out", 32'(fmadOut), 32'd0);
`else
    chk("t4a_out", 32'(fmadOut), 32'd65511);
`endif
    chk("t4a_ovf", 32'(overflow), 32'd1);
    do_op(8'd2, 8'd3, 16'd10, 1'b0, 1'b1, 1'b0, 1'b0, -1, lat);
    chk("t4b_out", 32'(fmadOut), 32'd4);
    chk("t4b_ovf", 32'(overflow), 32'd0);

    // 5. Accumulate chain, second op launched from DONE
    do_op(8'd3, 8'd4, 16'd10, 1'b0, 1'b0, 1'b0, 1'b0, -1, lat);
    chk("t5a_out", 32'(fmadOut), 32'd22);
    fmadMulIn1 = 8'd2; fmadMulIn2 = 8'd5; fmadAddIn = 16'd999;
    accumulate = 1'b1;
    start = 1'b1;
    lat = -1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      if (fmadDone) begin
        lat = e;
        break;
      end
    end
    chk("t5b_out", 32'(fmadOut), 32'd32);
    chk("t5b_gap", 32'(lat), 32'd6);
    accumulate = 1'b0;

    // 6. Reset mid-operation
    @(negedge clock);
    fmadMulIn1 = 8'd9; fmadMulIn2 = 8'd9; fmadAddIn = 16'd1;
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2;
    chk("t6_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_out", 32'(fmadOut), 32'd0);
    chk("t6_ovf", 32'(overflow), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    seen_done = 0;
    for (int e = 0; e < 10; e++) begin
      @(negedge clock);
      if (fmadDone) seen_done++;
    end
    chk("t6_no_done", 32'(seen_done), 32'd0);

    // start pulse during MUL must be ignored
    do_op(8'd3, 8'd4, 16'd10, 1'b0, 1'b0, 1'b0, 1'b0, 2, lat);
    chk("t6_ign_out", 32'(fmadOut), 32'd22);
    chk("t6_ign_lat", 32'(lat), 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fmad_iter.md
# fmad_iter

Iterative, parametrised fused multiply-add unit: computes `±(M1·M2) ± A` in `2·WIDTH` bits, retiring `STEP` multiplier bits per cycle. It is the successor to the fixed-width integer `fmad`, adding:
- a signed/unsigned mode;
- an accumulate mode that chains results without a round trip;
- overflow detection, with optional saturation.

It sits beside the FPU datapath as the integer MAD engine and uses the same start/done handshake.

## Interface
- `WIDTH`, default 8: multiplier operand width. Must be ≥ 2.
- `STEP`, default 2: multiplier bits retired per cycle. `WIDTH % STEP == 0` is required (elaboration-time `$error` otherwise).
- `clock`  in  1: the single clock.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: request an operation; sampled at posedge.
- `fmadMulIn1`, `fmadMulIn2`  in  WIDTH: multiplicands.
- `fmadAddIn`  in  2·WIDTH: addend.
- `sub`  in  1: 1 means subtract the addend.
- `negate`  in  1: 1 means negate the product.
- `signedMode`  in  1: 1 means treat all operands and the result as two's complement.
- `accumulate`  in  1: 1 means use the current `fmadOut` as the addend instead of `fmadAddIn`.
- `busy`  out  1: high whenever state ≠ IDLE.
- `fmadDone`  out  1: one-cycle completion pulse.
- `fmadOut`  out  2·WIDTH: result, held until the next completion.
- `overflow`  out  1: the exact result was out of range; updated with `fmadOut`.

## Operation
- Result definition: `R = (negate ? −P : P) + (sub ? −A : A)`, with `P = M1·M2`.
  - `A` is `fmadAddIn`, or the previous `fmadOut` when `accumulate` is set.
- FSM states (in `fmad_pkg`): IDLE, MUL, ADD, DONE.
- IDLE or DONE, with `start` = 1 at posedge:
  - latch the operands and all mode bits;
  - load `N = WIDTH/STEP` into the step counter;
  - clear the partial product;
  - go to MUL.
- `start` in MUL or ADD is ignored; there is no queueing.
- Signed multiply uses magnitude and sign:
  - at latch, operands are replaced by their absolute values (`−2^(WIDTH−1)` maps to `2^(WIDTH−1)`, which fits unsigned);
  - the product sign is `sign1 ^ sign2 ^ negate`.
- MUL, once per cycle:
  - `pp += (mcand · mplier[STEP−1:0]) << shift`;
  - `mplier >>= STEP`; `shift += STEP`; counter decrements;
  - at counter == 1, go to ADD.
- ADD:
  - apply the product sign;
  - form the exact sum in `2·WIDTH+2` bits;
  - range-check, then register `fmadOut` and `overflow`;
  - go to DONE.
- Range:
  - signed mode: `[−2^(2W−1), 2^(2W−1)−1]`;
  - unsigned mode: `[0, 2^(2W)−1]`; a negative result is out of range.
- DONE: `fmadDone` = 1 for this cycle only; go to IDLE, or to MUL if `start` = 1.
- Reset, including mid-operation: the state goes to IDLE immediately and the in-flight operation is discarded. `fmadOut`, `overflow`, `fmadDone` and `busy` all go to 0.

## Timing
- `start` is sampled at edge 0.
- MUL occupies edges 1..N.
- `fmadOut`, `overflow` and `fmadDone` are registered at edge N+1.
- `fmadDone` is high during the cycle after edge N+1, so latency is N+1 edges.
- Back-to-back: a `start` held at edge N+2, while in DONE, launches the next operation. Throughput is one result per N+2 cycles.
- Accumulate in back-to-back operation reads the `fmadOut` registered at edge N+1 of the previous operation.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `FMAD_SAT_EN` defined: an out-of-range result is clamped to the nearest bound (signed or unsigned range) and `overflow` = 1.
- `FMAD_SAT_EN` undefined: the result wraps to its low `2·WIDTH` bits; `overflow` is still reported.

## Structure
- `fmad_pkg`: `fmad_state_t` enum, `fmad_op_t` struct (`sub`, `negate`, `signedMode`, `accumulate`, product sign), and a `SUM_EXTRA = 2` constant.
- One sub-module, `fmad_step`: combinational STEP-bit partial-product generate-and-add, parametrised by WIDTH and STEP.

## Test plan
All scenarios use WIDTH = 8, STEP = 2, so N = 4.
1. Unsigned `200·100 + 1000`:
   - `fmadOut` = 21000;
   - `fmadDone` is asserted exactly 5 edges after start and lasts one cycle;
   - `overflow` = 0.
2. Signed `−128·−128 + 0` gives 16384. Signed `−3·5`, with `sub`, `A` = 7, gives −22 (`0xFFEA`). `overflow` = 0 in both.
3. Unsigned `255·255 + 65535`:
   - with `FMAD_SAT_EN`: `fmadOut` = 65535;
   - without it: `fmadOut` = 65024;
   - `overflow` = 1 in both builds.
4. Unsigned `negate`, `5·5 + 0`:
   - with `FMAD_SAT_EN`: `fmadOut` = 0;
   - without it: `fmadOut` = 65511;
   - `overflow` = 1. In contrast, `negate`, `2·3 + 10` gives 4 with `overflow` = 0.
5. Accumulate chain:
   - `3·4 + 10` gives 22;
   - then `2·5` with `accumulate` issued back-to-back (start held in DONE) gives 32;
   - the second `fmadDone` arrives 6 edges after the first.
6. Reset mid-operation: start, then assert `reset` after 2 edges.
   - Immediately: `busy`, `fmadOut` and `overflow` = 0, and no `fmadDone` occurs.
   - A `start` pulse in MUL (no reset) is ignored, and the result is unchanged.
